// File: rtl/seg_s2p_rx.sv
// Receiver for the serial 7-segment link: oversamples SEG_CLK/DT/CLR/EN in the clk domain,
// rebuilds each frame and decodes every byte into a hex digit, a match flag and a decimal point.
module seg_s2p_rx #(
    parameter int FRAME_BITS     = 64,
    parameter int IDLE_TIMEOUT   = 1024,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      seg_clk,
    input  logic                      seg_dt,
    input  logic                      seg_clr,
    input  logic                      seg_en,
    output logic [FRAME_BITS-1:0]     frame_data,
    output logic                      frame_valid,
    output logic                      frame_err,
    output logic [4*FRAME_BITS/8-1:0] digits,
    output logic [FRAME_BITS/8-1:0]   digit_ok,
    output logic [FRAME_BITS/8-1:0]   dp,
    output logic [6:0]                bit_cnt
);

    localparam int NBYTES = FRAME_BITS / 8;
    localparam int IW     = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [6:0]    LAST_BIT  = 7'(FRAME_BITS - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Returns {ok, dp, digit[3:0]} for one received byte.
    function automatic logic [5:0] decode_glyph(input logic [7:0] raw);
        logic [7:0] s;
        logic [3:0] d;
        logic       ok;
        s  = (SEG_ACTIVE_LOW != 0) ? ~raw : raw;
        d  = 4'h0;
        ok = 1'b1;
        case (s[6:0])
            7'h3F: d = 4'h0;
            7'h06: d = 4'h1;
            7'h5B: d = 4'h2;
            7'h4F: d = 4'h3;
            7'h66: d = 4'h4;
            7'h6D: d = 4'h5;
            7'h7D: d = 4'h6;
            7'h07: d = 4'h7;
            7'h7F: d = 4'h8;
            7'h6F: d = 4'h9;
            7'h77: d = 4'hA;
            7'h7C: d = 4'hB;
            7'h39: d = 4'hC;
            7'h5E: d = 4'hD;
            7'h79: d = 4'hE;
            7'h71: d = 4'hF;
            default: begin
                d  = 4'h0;
                ok = 1'b0;
            end
        endcase
        return {ok, s[7], d};
    endfunction

    // Two-flop synchronizers plus the previous synchronized clock for edge detection
    logic clk_sync_p0, clk_sync_p1, prev_clk;
    logic dt_sync_p0, dt_sync_p1;
    logic clr_sync_p0, clr_sync_p1;
    logic en_sync_p0, en_sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_p0 <= 1'b0;
            clk_sync_p1 <= 1'b0;
            prev_clk    <= 1'b0;
            dt_sync_p0  <= 1'b0;
            dt_sync_p1  <= 1'b0;
            clr_sync_p0 <= 1'b0;
            clr_sync_p1 <= 1'b0;
            en_sync_p0  <= 1'b0;
            en_sync_p1  <= 1'b0;
        end else begin
            clk_sync_p0 <= seg_clk;
            clk_sync_p1 <= clk_sync_p0;
            prev_clk    <= clk_sync_p1;
            dt_sync_p0  <= seg_dt;
            dt_sync_p1  <= dt_sync_p0;
            clr_sync_p0 <= seg_clr;
            clr_sync_p1 <= clr_sync_p0;
            en_sync_p0  <= seg_en;
            en_sync_p1  <= en_sync_p0;
        end
    end

    logic                    edge_p1;
    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [6:0]              cnt_d;
    logic [IW-1:0]           idle_q, idle_d;
    logic [FRAME_BITS-1:0]   frame_d;
    logic                    vld_d, err_d;
    logic [4*NBYTES-1:0]     dig_d;
    logic [NBYTES-1:0]       ok_d, dp_d;
    logic [5:0]              glyph;

    assign edge_p1 = clk_sync_p1 & ~prev_clk;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = bit_cnt;
        idle_d  = idle_q;
        frame_d = frame_data;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        // Clear beats a coincident edge; an accepted edge beats a coincident timeout.
        if (!clr_sync_p1) begin
            state_d = IDLE;
            shift_d = '0;
            cnt_d   = '0;
            idle_d  = '0;
        end else if (edge_p1 && en_sync_p1) begin
            idle_d = '0;
            if (bit_cnt == LAST_BIT) begin
                frame_d = {shift_q[FRAME_BITS-2:0], dt_sync_p1};
                vld_d   = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], dt_sync_p1};
                cnt_d   = bit_cnt + 7'd1;
                state_d = SHIFT;
            end
        end else if (state_q == SHIFT) begin
            if (idle_q == IDLE_LAST) begin
                shift_d = '0;
                cnt_d   = '0;
                idle_d  = '0;
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                idle_d = idle_q + IW'(1);
            end
        end
    end

    always_comb begin
        dig_d = '0;
        ok_d  = '0;
        dp_d  = '0;
        glyph = '0;
        for (int i = 0; i < NBYTES; i++) begin
            glyph            = decode_glyph(frame_d[8*i +: 8]);
            dig_d[4*i +: 4]  = glyph[3:0];
            dp_d[i]          = glyph[4];
            ok_d[i]          = glyph[5];
        end
    end

    // Frame/decode register stage: one clk after the detected final edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt     <= '0;
            idle_q      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            digits      <= '0;
            digit_ok    <= '0;
            dp          <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt     <= cnt_d;
            idle_q      <= idle_d;
            frame_valid <= vld_d;
            frame_err   <= err_d;
            if (vld_d) begin
                frame_data <= frame_d;
                digits     <= dig_d;
                digit_ok   <= ok_d;
                dp         <= dp_d;
            end
        end
    end

endmodule

// File: tb/tb_seg_s2p_rx.sv
// Directed bench for seg_s2p_rx: table of frames with hand-decoded digits, plus
// sequences for idle, timeout, link clear, back-to-back frames and mid-frame reset.
module tb_seg_s2p_rx;

    localparam int FB = 64;
    localparam int TO = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seg_clk = 1'b0;
    logic          seg_dt = 1'b0;
    logic          seg_clr = 1'b1;
    logic          seg_en = 1'b1;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic [31:0]   digits;
    logic [7:0]    digit_ok;
    logic [7:0]    dp;
    logic [6:0]    bit_cnt;

    seg_s2p_rx #(.FRAME_BITS(FB), .IDLE_TIMEOUT(TO), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .seg_clk(seg_clk), .seg_dt(seg_dt),
        .seg_clr(seg_clr), .seg_en(seg_en), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_err(frame_err), .digits(digits),
        .digit_ok(digit_ok), .dp(dp), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (frame_valid) valid_cnt++;
        if (frame_err) err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, summary follows");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] word;
        logic [31:0] exp_digits;
        logic [7:0]  exp_ok;
        logic [7:0]  exp_dp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi);
        @(negedge clk);
        seg_clk = 1'b0;
        seg_dt  = b;
        clks(lo);
        seg_clk = 1'b1;
        clks(hi);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n, input int lo, input int hi);
        for (int i = 63; i > 63 - n; i--) send_bit(w[i], lo, hi);
    endtask

    task automatic check_frame(input string name, input logic [63:0] w,
                               input logic [31:0] d, input logic [7:0] ok, input logic [7:0] p);
        check({name, ".data"}, frame_data, w);
        check({name, ".digits"}, 64'(digits), 64'(d));
        check({name, ".ok"}, 64'(digit_ok), 64'(ok));
        check({name, ".dp"}, 64'(dp), 64'(p));
    endtask

    int v0, e0;

    initial begin
        vecs[0] = '{64'hFFFFFFFFFFFF9290, 32'h00000059, 8'h03, 8'h00};
        vecs[1] = '{64'h4040404040404040, 32'h00000000, 8'hFF, 8'hFF};
        vecs[2] = '{64'hC0F9A4B0999282F8, 32'h01234567, 8'hFF, 8'h00};
        vecs[3] = '{64'h80908883C6A1868E, 32'h89ABCDEF, 8'hFF, 8'h00};
        vecs[4] = '{64'hFFFFFFFFFFFFC0A5, 32'h00000000, 8'h02, 8'h00};
        vecs[5] = '{64'hFFFFFFFFFFFFFF00, 32'h00000008, 8'h01, 8'h01};

        // Reset state
        clks(3);
        check("rst.frame_data", frame_data, 64'h0);
        check("rst.frame_valid", 64'(frame_valid), 64'h0);
        check("rst.frame_err", 64'(frame_err), 64'h0);
        check("rst.digits", 64'(digits), 64'h0);
        check("rst.digit_ok", 64'(digit_ok), 64'h0);
        check("rst.dp", 64'(dp), 64'h0);
        check("rst.bit_cnt", 64'(bit_cnt), 64'h0);
        rst_n = 1'b1;

        // Long idle must not time out
        e0 = err_cnt;
        clks(5000);
        check("idle.no_err", 64'(err_cnt - e0), 64'h0);

        // Table of full frames
        for (int k = 0; k < 6; k++) begin
            v0 = valid_cnt;
            send_bits(vecs[k].word, FB, 4, 4);
            clks(4);
            check($sformatf("vec%0d.valid_pulses", k), 64'(valid_cnt - v0), 64'h1);
            check($sformatf("vec%0d.bit_cnt", k), 64'(bit_cnt), 64'h0);
            check_frame($sformatf("vec%0d", k), vecs[k].word, vecs[k].exp_digits,
                        vecs[k].exp_ok, vecs[k].exp_dp);
        end

        // Partial frame, ignored shifts while disabled, then timeout
        e0 = err_cnt;
        v0 = valid_cnt;
        send_bits(64'h123456789ABCDEF0, 20, 4, 4);
        check("to.bit_cnt20", 64'(bit_cnt), 64'd20);
        seg_en = 1'b0;
        clks(4);
        send_bits(64'hFFFFFFFFFFFFFFFF, 3, 4, 4);
        check("en_low.bit_cnt_held", 64'(bit_cnt), 64'd20);
        seg_en = 1'b1;
        clks(4);
        check("to.no_err_yet", 64'(err_cnt - e0), 64'h0);
        clks(TO + 20);
        check("to.err_pulses", 64'(err_cnt - e0), 64'h1);
        check("to.bit_cnt0", 64'(bit_cnt), 64'h0);
        check("to.frame_held", frame_data, vecs[5].word);
        check("to.no_valid", 64'(valid_cnt - v0), 64'h0);
        send_bits(vecs[2].word, FB, 4, 4);
        clks(4);
        check_frame("after_to", vecs[2].word, vecs[2].exp_digits, vecs[2].exp_ok, vecs[2].exp_dp);

        // Link clear mid-frame
        e0 = err_cnt;
        v0 = valid_cnt;
        send_bits(64'hAAAAAAAAAAAAAAAA, 30, 4, 4);
        check("clr.bit_cnt30", 64'(bit_cnt), 64'd30);
        seg_clr = 1'b0;
        clks(4);
        check("clr.bit_cnt0", 64'(bit_cnt), 64'h0);
        check("clr.frame_held", frame_data, vecs[2].word);
        seg_clr = 1'b1;
        clks(4);
        send_bits(vecs[1].word, FB, 4, 4);
        clks(4);
        check("clr.valid_pulses", 64'(valid_cnt - v0), 64'h1);
        check("clr.no_err", 64'(err_cnt - e0), 64'h0);
        check_frame("clr", vecs[1].word, vecs[1].exp_digits, vecs[1].exp_ok, vecs[1].exp_dp);

        // Back-to-back frames at the minimum link timing
        v0 = valid_cnt;
        send_bits(vecs[0].word, FB, 3, 3);
        send_bits(vecs[3].word, FB, 3, 3);
        clks(4);
        check("b2b.valid_pulses", 64'(valid_cnt - v0), 64'h2);
        check_frame("b2b", vecs[3].word, vecs[3].exp_digits, vecs[3].exp_ok, vecs[3].exp_dp);

        // Reset mid-frame
        send_bits(64'h5555555555555555, 30, 4, 4);
        @(negedge clk);
        seg_clk = 1'b0;
        clks(4);
        rst_n = 1'b0;
        clks(3);
        check("mrst.bit_cnt", 64'(bit_cnt), 64'h0);
        check("mrst.frame_data", frame_data, 64'h0);
        rst_n = 1'b1;
        clks(4);
        v0 = valid_cnt;
        send_bits(vecs[4].word, FB, 4, 4);
        clks(4);
        check("mrst.valid_pulses", 64'(valid_cnt - v0), 64'h1);
        check_frame("mrst", vecs[4].word, vecs[4].exp_digits, vecs[4].exp_ok, vecs[4].exp_dp);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg_s2p_rx.md
Name: seg_s2p_rx

Overview:
- Serial-to-parallel receiver for the 7-segment display link driven by the team's parallel-to-serial segment shifter (SEG_CLK / SEG_DT / SEG_CLR / SEG_EN).
- Oversamples the link in the system clock domain and reassembles each 64-bit segment frame.
- Decodes each frame into eight hex digits plus decimal points.
- Sits on the receiving side in self-check benches and in a second-board display mirror.

Parameters:
- FRAME_BITS, 64, bits per frame; must be a multiple of 8.
- IDLE_TIMEOUT, 1024, clk cycles without a SEG_CLK rising edge before a partial frame is discarded.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_clk  in  1  link shift clock; asynchronous to clk.
- seg_dt  in  1  link serial data; sampled on seg_clk rising edge.
- seg_clr  in  1  link clear, active-low.
- seg_en  in  1  link enable; shifts are ignored while low.
- frame_data  out  FRAME_BITS  last complete frame; first bit received lands in the MSB.
- frame_valid  out  1  one-cycle pulse when frame_data updates.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded by timeout.
- digits  out  4*FRAME_BITS/8  decoded hex per byte; byte 7 (bits 63:56) maps to digits[31:28].
- digit_ok  out  FRAME_BITS/8  1 = the byte matched a hex glyph.
- dp  out  FRAME_BITS/8  decimal point lit, polarity-corrected.
- bit_cnt  out  7  bits received in the current frame, for debug.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, shift register 0, bit counter 0, idle counter 0, synchronizers cleared.
- Synchronization: seg_clk, seg_dt, seg_clr and seg_en each pass through 2 flops. A prev_clk flop provides edge detection.
- Rising edge is detected when the synchronized seg_clk is 1 and prev_clk is 0. seg_dt is taken from its synchronizer in that same cycle.
- Link timing requirement: seg_clk high ≥3 clk, low ≥3 clk; seg_dt stable ≥2 clk on each side of the rising edge.
- Shift, on an edge with seg_en_s=1 and seg_clr_s=1:
  - shift register becomes {shift[FRAME_BITS-2:0], seg_dt_s}.
  - bit_cnt increments.
  - idle counter clears.
- States: IDLE (bit_cnt=0) and SHIFT (0<bit_cnt<FRAME_BITS).
  - IDLE→SHIFT on the first accepted edge.
  - SHIFT→IDLE on the FRAME_BITS-th edge, on timeout, or when seg_clr is asserted.
- Frame completion: on the cycle the FRAME_BITS-th bit is accepted, the next clk edge loads frame_data with the completed word and sets frame_valid=1 for exactly 1 cycle; bit_cnt returns to 0.
- Decode outputs (digits, digit_ok, dp) are registered on the same edge as frame_data, computed from the new word. Total latency from the detected last edge: 1 clk.
- Glyph decode:
  - If SEG_ACTIVE_LOW=1, invert the byte first.
  - bit7 = dp; bits 6..0 = g..a.
  - Table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
  - No match (including blank): digit_ok=0, digit=0.
- Timeout: the idle counter increments in SHIFT only. When it reaches IDLE_TIMEOUT-1, the shift register and bit_cnt clear, frame_err pulses for 1 cycle, and frame_data is unchanged. The counter is held at 0 in IDLE.
- seg_clr_s=0: shift register and bit_cnt clear, no frame_err, frame_data/digits held. An edge in the same cycle is dropped, because clear wins.
- seg_en_s=0: edges are ignored; partial state is held, and the idle counter still runs.
- Back-to-back frames: the first edge of the next frame may occur in the same cycle frame_valid is high; it is accepted as bit 1 of the new frame.
- rst_n asserted mid-frame discards everything. After deassertion, the first accepted edge is treated as bit 1.

Test Plan:
- Reset → all outputs 0. Release, no activity for 5000 clk → frame_err never pulses (counter does not run in IDLE).
- Send bytes FF FF FF FF FF FF 92 90 MSB-first, seg_clk period 8 clk → single frame_valid:
  - frame_data = 64'hFFFFFFFFFFFF9290.
  - digits[7:0] = 8'h59; digit_ok = 8'b00000011; dp = 0.
- Send 20 bits, then stop for IDLE_TIMEOUT clk → frame_err pulses once, bit_cnt = 0, frame_data unchanged. A following full frame then decodes correctly.
- After 30 bits, assert seg_clr for 4 clk, then send a fresh 64-bit frame of byte C0 with dp lit (40) → no frame_err, no frame_valid until the fresh frame completes:
  - frame_data = 64'h4040404040404040.
  - digits = 0, digit_ok = FF, dp = FF.
- Two frames with zero gap → exactly two frame_valid pulses, second frame_data correct.
- Byte A5 in digit 0 → digit_ok[0] = 0, digits[3:0] = 0. Assert rst_n mid-frame → next full frame decodes correctly.
